// File: rtl/multi_tick_gen_if.sv
// ---------------------------------------------------------------------------
// multi_tick_gen_if
// Bundles the run/configuration inputs and the per-channel tick outputs of
// multi_tick_gen. clk and reset stay plain ports on the module itself.
//
// Signals:
//   enable     global run enable; low freezes every channel
//   cfg_we     configuration write strobe
//   cfg_ch     channel addressed by cfg_we (CH_W bits)
//   cfg_max    new period in clk cycles (CNT_WIDTH bits)
//   cfg_mode   new mode: 00 off, 01 pulse, 10 toggle, 11 one-shot
//   start      per-channel restart/arm strobe (NUM_CH bits)
//   tick       one-cycle pulse per terminal count (NUM_CH bits)
//   wave       toggle output, flips each terminal count in mode 10
//   busy       channel is actively counting
//   rd_ch      (TICK_COUNT_EN only) channel selected for tick_count
//   tick_count (TICK_COUNT_EN only) registered saturating tick count
//
// Modports: master drives configuration (system side), slave is the
// generator.
// ---------------------------------------------------------------------------
interface multi_tick_gen_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 enable;
    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [CNT_WIDTH-1:0] cfg_max;
    logic [1:0]           cfg_mode;
    logic [NUM_CH-1:0]    start;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    wave;
    logic [NUM_CH-1:0]    busy;
`ifdef TICK_COUNT_EN
    logic [CH_W-1:0]      rd_ch;
    logic [15:0]          tick_count;
`endif

    modport master (
        output enable, cfg_we, cfg_ch, cfg_max, cfg_mode, start,
`ifdef TICK_COUNT_EN
        output rd_ch,
        input  tick_count,
`endif
        input  tick, wave, busy
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_max, cfg_mode, start,
`ifdef TICK_COUNT_EN
        input  rd_ch,
        output tick_count,
`endif
        output tick, wave, busy
    );
endinterface

// File: rtl/multi_tick_gen.sv
// ---------------------------------------------------------------------------
// multi_tick_gen
// Multi-channel tick / clock-enable generator. Each of NUM_CH channels has a
// runtime-programmable period and mode (off, periodic pulse, periodic toggle,
// one-shot). A channel with period N emits one registered tick every N
// enabled cycles; in toggle mode its wave output flips on every tick.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset (overrides cfg_we and start)
//   bus    multi_tick_gen_if.slave: enable, cfg_we/cfg_ch/cfg_max/cfg_mode,
//          start[], tick[], wave[], busy[] (+ rd_ch/tick_count, see below)
//
// Optional feature macro TICK_COUNT_EN: when defined, each channel keeps a
// 16-bit saturating count of emitted ticks, readable through rd_ch with one
// cycle of latency on tick_count. Counts clear on reset and on cfg_we to the
// channel (start does not clear them).
// ---------------------------------------------------------------------------
module multi_tick_gen #(
    parameter int                   NUM_CH      = 4,
    parameter int                   CNT_WIDTH   = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_MAX = CNT_WIDTH'(50000000)
) (
    input  logic             clk,
    input  logic             reset,
    multi_tick_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_PULSE   = 2'b01,
        MODE_TOGGLE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    logic [CNT_WIDTH-1:0] period_q [NUM_CH];
    logic [CNT_WIDTH-1:0] period_d [NUM_CH];
    mode_e                mode_q   [NUM_CH];
    mode_e                mode_d   [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d    [NUM_CH];

    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wave_q, wave_d;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] at_tc;
    logic [NUM_CH-1:0] cfg_hit;

    // Channel status decode. A channel counts only with a non-zero period,
    // a mode other than off, and not after its one-shot has fired.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // Out-of-range cfg_ch values match no channel, so such writes
            // are dropped without extra logic.
            cfg_hit[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);
            run[i]     = (mode_q[i] != MODE_OFF) &&
                         (period_q[i] != '0) &&
                         !((mode_q[i] == MODE_ONESHOT) && done_q[i]);
            // Only meaningful when run[i] is set (period non-zero), so the
            // subtraction never underflows where it matters.
            at_tc[i]   = (cnt_q[i] == (period_q[i] - CNT_WIDTH'(1)));
        end
    end

    // Next-state logic. Priority per channel: cfg_we, then start, then the
    // enabled count. cfg_we and start both suppress a tick that would
    // otherwise fire on a terminal-count cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            mode_d[i]   = mode_q[i];
            cnt_d[i]    = cnt_q[i];
            done_d[i]   = done_q[i];
            tick_d[i]   = 1'b0;
            wave_d[i]   = wave_q[i];

            if (cfg_hit[i]) begin
                period_d[i] = bus.cfg_max;
                mode_d[i]   = mode_e'(bus.cfg_mode);
                cnt_d[i]    = '0;
                done_d[i]   = 1'b0;
            end else if (bus.start[i]) begin
                cnt_d[i]    = '0;
                done_d[i]   = 1'b0;
            end else if (bus.enable && run[i]) begin
                if (at_tc[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    if (mode_q[i] == MODE_TOGGLE) begin
                        wave_d[i] = ~wave_q[i];
                    end
                    if (mode_q[i] == MODE_ONESHOT) begin
                        done_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stage boundary: channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= DEFAULT_MAX;
                mode_q[i]   <= MODE_PULSE;
                cnt_q[i]    <= '0;
            end
            done_q <= '0;
            tick_q <= '0;
            wave_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                mode_q[i]   <= mode_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            done_q <= done_d;
            tick_q <= tick_d;
            wave_q <= wave_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.wave = wave_q;
    // busy is a pure function of configuration, so it stays valid while
    // enable is low.
    assign bus.busy = run;

`ifdef TICK_COUNT_EN
    logic [15:0] tcnt_q [NUM_CH];
    logic [15:0] tcnt_d [NUM_CH];
    logic [15:0] rd_q, rd_d;

    // Count follows tick_d so the count register and tick rise together.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tcnt_d[i] = tcnt_q[i];
            if (cfg_hit[i]) begin
                tcnt_d[i] = '0;
            end else if (tick_d[i] && (tcnt_q[i] != 16'hFFFF)) begin
                tcnt_d[i] = tcnt_q[i] + 16'd1;
            end
        end
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.rd_ch) == i) begin
                rd_d = tcnt_q[i];
            end
        end
    end

    // Stage boundary: tick counters and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tcnt_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tcnt_q[i] <= tcnt_d[i];
            end
            rd_q <= rd_d;
        end
    end

    assign bus.tick_count = rd_q;
`endif

endmodule
